bounce_meter: RTL and testbench

- Measurement controller that sequences one bounce capture on a raw switch input.
- Arms on request, starts a fixed window on the first edge, and counts every edge inside that window.
- Records when the last edge occurred, then holds the result for the 8-digit 7-segment display path.
- Sits between the board switch/KEY inputs and the displayNdigit datapath, replacing the free-running bounce counter.

---
 rtl/bounce_pkg.sv | 14 +
 rtl/sync_edge_detect.sv | 32 +++
 rtl/bounce_meter.sv | 147 ++++++++++++++
 tb/tb_bounce_meter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bounce_pkg.sv
// Shared types and defaults for the bounce measurement controller.
package bounce_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2,
    HOLD    = 2'd3
  } meter_state_t;

  // 50 ms at 50 MHz
  localparam int unsigned DEFAULT_WINDOW_CYCLES = 2_500_000;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous pin followed by a
// rise-or-fall edge detector. edge_pulse is high for one cycle per toggle,
// 2-3 cycles after the pin changes.
module sync_edge_detect
  import bounce_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic edge_pulse
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  // Metastability filter (p0, p1) and one-cycle history (p2) for edge compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      sync_p0 <= raw_in;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign edge_pulse = sync_p1 ^ prev_p2;

endmodule

// File: rtl/bounce_meter.sv
// Bounce measurement controller: arm, open a fixed window on the first
// synchronized edge, count edges inside it, record the relative cycle of the
// last edge, then hold the results for display.
// Optional feature: define BOUNCE_MAX_GAP_EN to build the longest
// inter-edge gap tracker; otherwise max_gap is tied to zero.
module bounce_meter
  import bounce_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = DEFAULT_WINDOW_CYCLES,
  parameter int          CNT_W         = 16,
  parameter int          TIME_W        = 24
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              raw_in,
  input  logic              arm,
  input  logic              clear,
  output logic [CNT_W-1:0]  edge_count,
  output logic [TIME_W-1:0] settle_cycles,
  output logic [TIME_W-1:0] max_gap,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state
);

  // Relative index of the final window cycle; timer_q holds the relative
  // index of the current MEASURE cycle, so it starts at 1 on entry.
  localparam logic [TIME_W-1:0] LAST_CYCLE = TIME_W'(WINDOW_CYCLES - 1);
  localparam logic [TIME_W-1:0] TIME_ONE   = TIME_W'(1);

  meter_state_t      state_q;
  meter_state_t      state_d;
  logic              edge_det;
  logic [TIME_W-1:0] timer_q;
  logic              window_end;
  logic              zero_res;
  logic              first_edge;
  logic              count_edge;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  sync_edge_detect u_sync (
    .clk        (CLOCK_50),
    .rst_n      (reset_n),
    .raw_in     (raw_in),
    .edge_pulse (edge_det)
  );

  assign window_end = (timer_q == LAST_CYCLE);

  // State register
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and datapath strobes; clear overrides arm and edges
  always_comb begin
    state_d    = state_q;
    zero_res   = 1'b0;
    first_edge = 1'b0;
    count_edge = 1'b0;
    if (clear) begin
      state_d  = IDLE;
      zero_res = 1'b1;
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          if (arm) begin
            state_d  = ARMED;
            zero_res = 1'b1;
          end
        end
        ARMED: begin
          if (edge_det) begin
            state_d    = MEASURE;
            first_edge = 1'b1;
          end
        end
        MEASURE: begin
          count_edge = edge_det;
          if (window_end) state_d = HOLD;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Window timer: relative cycle index while measuring
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n)                              timer_q <= '0;
    else if (first_edge)                       timer_q <= TIME_ONE;
    else if (state_q == MEASURE && !window_end) timer_q <= timer_q + TIME_ONE;
  end

  // Edge count and last-edge time
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      edge_count    <= '0;
      settle_cycles <= '0;
    end else if (zero_res) begin
      edge_count    <= '0;
      settle_cycles <= '0;
    end else if (first_edge) begin
      edge_count    <= CNT_W'(1);
      settle_cycles <= '0;
    end else if (count_edge) begin
      edge_count    <= sat_inc(edge_count);
      settle_cycles <= timer_q;
    end
  end

`ifdef BOUNCE_MAX_GAP_EN
  logic [TIME_W-1:0] last_k_q;
  logic [TIME_W-1:0] max_gap_q;
  logic [TIME_W-1:0] gap;

  assign gap = timer_q - last_k_q;

  // Longest interval between consecutive counted edges
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      last_k_q  <= '0;
      max_gap_q <= '0;
    end else if (zero_res) begin
      last_k_q  <= '0;
      max_gap_q <= '0;
    end else if (first_edge) begin
      last_k_q  <= '0;
    end else if (count_edge) begin
      last_k_q <= timer_q;
      if (gap > max_gap_q) max_gap_q <= gap;
    end
  end

  assign max_gap = max_gap_q;
`else
  assign max_gap = '0;
`endif

  assign busy  = (state_q == ARMED) || (state_q == MEASURE);
  assign done  = (state_q == HOLD);
  assign state = state_q;

endmodule

// File: tb/tb_bounce_meter.sv
// Directed bench for bounce_meter with a 100-cycle window. A second
// instance with a 4-bit counter shares the stimulus for saturation checks.
module tb_bounce_meter;

  localparam int WIN = 100;
`ifdef BOUNCE_MAX_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  typedef struct {
    logic [127:0] tog;
    int           exp_count;
    int           exp_settle;
    int           exp_gap;
    int           exp_count4;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        raw_in = 1'b0;
  logic        arm = 1'b0;
  logic        clear = 1'b0;

  logic [15:0] edge_count;
  logic [7:0]  settle_cycles;
  logic [7:0]  max_gap;
  logic        busy;
  logic        done;
  logic [1:0]  state;

  logic [3:0]  edge_count4;
  logic [7:0]  settle_cycles4;
  logic [7:0]  max_gap4;
  logic        busy4;
  logic        done4;
  logic [1:0]  state4;

  int vec_cnt = 0;
  int err_cnt = 0;
  vec_t vecs [4];

  bounce_meter #(.WINDOW_CYCLES(WIN), .CNT_W(16), .TIME_W(8)) dut (
    .CLOCK_50(clk), .reset_n(reset_n), .raw_in(raw_in), .arm(arm), .clear(clear),
    .edge_count(edge_count), .settle_cycles(settle_cycles), .max_gap(max_gap),
    .busy(busy), .done(done), .state(state)
  );

  bounce_meter #(.WINDOW_CYCLES(WIN), .CNT_W(4), .TIME_W(8)) dut4 (
    .CLOCK_50(clk), .reset_n(reset_n), .raw_in(raw_in), .arm(arm), .clear(clear),
    .edge_count(edge_count4), .settle_cycles(settle_cycles4), .max_gap(max_gap4),
    .busy(busy4), .done(done4), .state(state4)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", what, act, exp);
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (4) tick();
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    // Toggle at step j after arming produces a detected edge at relative cycle j
    foreach (vecs[i]) vecs[i].tog = '0;
    vecs[0].tog[0] = 1'b1; vecs[0].tog[5] = 1'b1; vecs[0].tog[12] = 1'b1;
    vecs[0].exp_count = 3;  vecs[0].exp_settle = 12; vecs[0].exp_gap = GAP_EN ? 7 : 0;
    vecs[0].exp_count4 = 3;
    vecs[1].tog[0] = 1'b1; vecs[1].tog[99] = 1'b1; vecs[1].tog[100] = 1'b1;
    vecs[1].exp_count = 2;  vecs[1].exp_settle = 99; vecs[1].exp_gap = GAP_EN ? 99 : 0;
    vecs[1].exp_count4 = 2;
    for (int k = 0; k < 20; k++) vecs[2].tog[2*k] = 1'b1;
    vecs[2].exp_count = 20; vecs[2].exp_settle = 38; vecs[2].exp_gap = GAP_EN ? 2 : 0;
    vecs[2].exp_count4 = 15;
    vecs[3].tog[0] = 1'b1;
    vecs[3].exp_count = 1;  vecs[3].exp_settle = 0;  vecs[3].exp_gap = 0;
    vecs[3].exp_count4 = 1;

    // Reset state
    #25;
    check("reset state", 32'(state), 0);
    check("reset edge_count", 32'(edge_count), 0);
    check("reset settle", 32'(settle_cycles), 0);
    check("reset max_gap", 32'(max_gap), 0);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();

    // Table-driven window captures
    for (int i = 0; i < 4; i++) begin
      pulse_clear();
      do_arm();
      check($sformatf("vec%0d armed state", i), 32'(state), 1);
      for (int j = 0; j <= 104; j++) begin
        if (j == 101) check($sformatf("vec%0d last window cycle state", i), 32'(state), 2);
        if (j == 102) check($sformatf("vec%0d hold entry state", i), 32'(state), 3);
        if (vecs[i].tog[j]) raw_in = ~raw_in;
        tick();
      end
      check($sformatf("vec%0d done", i), 32'(done), 1);
      check($sformatf("vec%0d busy", i), 32'(busy), 0);
      check($sformatf("vec%0d edge_count", i), 32'(edge_count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d settle_cycles", i), 32'(settle_cycles), 32'(vecs[i].exp_settle));
      check($sformatf("vec%0d max_gap", i), 32'(max_gap), 32'(vecs[i].exp_gap));
      check($sformatf("vec%0d edge_count cnt4", i), 32'(edge_count4), 32'(vecs[i].exp_count4));
      check($sformatf("vec%0d done cnt4", i), 32'(done4), 1);
    end

    // HOLD with arm and clear together: clear wins
    arm = 1'b1; clear = 1'b1;
    tick();
    arm = 1'b0; clear = 1'b0;
    check("hold arm+clear state", 32'(state), 0);
    check("hold arm+clear edge_count", 32'(edge_count), 0);
    check("hold arm+clear done", 32'(done), 0);

    // Armed with no edges waits indefinitely
    repeat (3) tick();
    do_arm();
    repeat (1000) tick();
    check("no edge state", 32'(state), 1);
    check("no edge busy", 32'(busy), 1);
    check("no edge done", 32'(done), 0);
    check("no edge edge_count", 32'(edge_count), 0);

    // Clear takes priority over a simultaneous first edge
    raw_in = ~raw_in;
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear vs edge state", 32'(state), 0);
    check("clear vs edge edge_count", 32'(edge_count), 0);
    repeat (4) tick();

    // Asynchronous reset in the middle of a measurement
    do_arm();
    for (int j = 0; j <= 42; j++) begin
      if (j == 42) begin
        check("pre-reset edge_count", 32'(edge_count), 6);
        check("pre-reset state", 32'(state), 2);
        reset_n = 1'b0;
        #1;
        check("mid reset state", 32'(state), 0);
        check("mid reset edge_count", 32'(edge_count), 0);
        check("mid reset settle", 32'(settle_cycles), 0);
        check("mid reset max_gap", 32'(max_gap), 0);
        check("mid reset busy", 32'(busy), 0);
        break;
      end
      if (j <= 10 && (j % 2) == 0) raw_in = ~raw_in;
      tick();
    end
    #5;
    reset_n = 1'b1;
    repeat (4) tick();

    // Restart after reset, then arm during MEASURE is ignored
    do_arm();
    raw_in = ~raw_in;
    repeat (3) tick();
    check("restart state", 32'(state), 2);
    check("restart edge_count", 32'(edge_count), 1);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("arm in measure state", 32'(state), 2);
    check("arm in measure edge_count", 32'(edge_count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
